// File: rtl/sampling_pkg.sv
// Shared constants and helpers for the sampling FIFO.
//   SAMPLING_DATA_WIDTH : default sample width
//   SAMPLING_DEPTH      : default number of history entries
//   ptr_w()             : width of a read/write pointer for a given depth
package sampling_pkg;

  localparam int SAMPLING_DATA_WIDTH = 8;
  localparam int SAMPLING_DEPTH      = 4;

  // Pointer width for a power-of-two depth; pointers wrap by natural overflow.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sampling_fifo_mem.sv
// History storage for the sampling FIFO: DEPTH x DATA_WIDTH array with one
// synchronous write port and one asynchronous read port. Contents are not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module sampling_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sampling_fifo.sv
// Sampling register plus show-ahead history FIFO with a sticky overflow flag.
//   clk        : clock (rising edge)
//   reset      : synchronous active-high reset
//   clear      : synchronous flush of FIFO contents and overflow flag
//   push_valid : push_data is a new sample this cycle
//   push_data  : sample value
//   sampled    : most recent sample presented with push_valid
//   pop_ready  : consumer accepts pop_data this cycle
//   pop_valid  : FIFO non-empty
//   pop_data   : oldest stored sample (show-ahead)
//   count      : number of stored entries
//   full       : count == DEPTH
//   overflow   : sticky, a sample was dropped while full
module sampling_fifo
  import sampling_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLING_DATA_WIDTH,
  parameter int DEPTH      = SAMPLING_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push_valid,
  input  logic [DATA_WIDTH-1:0]        push_data,
  output logic [DATA_WIDTH-1:0]        sampled,
  input  logic                         pop_ready,
  output logic                         pop_valid,
  output logic [DATA_WIDTH-1:0]        pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] sampled_q, sampled_d;

  logic pop;
  logic push_acc;
  logic mem_we;

  assign pop_valid = (count_q != '0);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = pop_valid && pop_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_acc  = push_valid && (!full || pop);
  // Flush and reset win over a same-cycle write; the slot is simply not used.
  assign mem_we    = push_acc && !clear && !reset;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    // The sample register follows push_valid even during a flush.
    sampled_d  = push_valid ? push_data : sampled_q;

    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)      rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_acc, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push_valid && !push_acc) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sampled_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sampled_q  <= sampled_d;
    end
  end

  sampling_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (push_data),
    .raddr (rd_ptr_q),
    .rdata (pop_data)
  );

  assign count    = count_q;
  assign overflow = overflow_q;
  assign sampled  = sampled_q;

endmodule

// File: tb/tb_sampling_fifo.sv
// Directed bench for sampling_fifo (DATA_WIDTH=8, DEPTH=4). Stimulus pushes the
// hand-computed values expected to leave the FIFO into a queue; a monitor
// compares every pop against the queue head.
module tb_sampling_fifo;

  logic       clk = 1'b0;
  logic       reset, clear, push_valid, pop_ready;
  logic [7:0] push_data;
  logic [7:0] sampled, pop_data;
  logic       pop_valid, full, overflow;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  sampling_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .push_valid (push_valid),
    .push_data  (push_data),
    .sampled    (sampled),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .count      (count),
    .full       (full),
    .overflow   (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pd, input logic pr,
                       input logic clr, input logic rst);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    clear      = clr;
    reset      = rst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic pv, input logic [7:0] pd, input logic pr,
                      input logic clr, input logic rst);
    drive(pv, pd, pr, clr, rst);
    tick();
  endtask

  // Monitor: every handshake pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && pop_valid && pop_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got %0h expected none", pop_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (pop_data !== e) begin
          fails++;
          $display("FAIL pop_data: got %0h expected %0h", pop_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    drive(0, 8'h00, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sampled", sampled, 0);

    // Three pushes, no pops
    step(1, 8'h11, 0, 0, 0); exp_q.push_back(8'h11);
    step(1, 8'h22, 0, 0, 0); exp_q.push_back(8'h22);
    step(1, 8'h33, 0, 0, 0); exp_q.push_back(8'h33);
    drive(0, 8'h00, 0, 0, 0);
    chk("t1_count", count, 3);
    chk("t1_head", pop_data, 8'h11);
    chk("t1_sampled", sampled, 8'h33);
    chk("t1_overflow", overflow, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t1_drained", count, 0);

    // Fill to full, fifth push dropped
    for (int i = 0; i < 4; i++) begin
      step(1, 8'hA0 + 8'(i), 0, 0, 0);
      exp_q.push_back(8'hA0 + 8'(i));
    end
    drive(0, 8'h00, 0, 0, 0);
    chk("t2_full", full, 1);
    chk("t2_ovf_before", overflow, 0);
    step(1, 8'hA4, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t2_ovf_after", overflow, 1);
    chk("t2_count", count, 4);
    chk("t2_sampled", sampled, 8'hA4);
    chk("t2_head", pop_data, 8'hA0);

    // Push and pop while full, long enough to wrap the pointers twice
    exp_q.push_back(8'h55);
    step(1, 8'h55, 1, 0, 0);
    chk("t3_count_0", count, 4);
    for (int i = 1; i < 10; i++) begin
      step(1, 8'h50 + 8'(i), 1, 0, 0);
      exp_q.push_back(8'h50 + 8'(i));
      chk("t3_count", count, 4);
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t3_empty", count, 0);
    chk("t3_ovf_sticky", overflow, 1);

    // Push with pop_ready while empty: no pop that cycle
    drive(1, 8'h7E, 1, 0, 0);
    #1;
    chk("t4_pv_before", pop_valid, 0);
    tick();
    exp_q.push_back(8'h7E);
    drive(0, 8'h00, 0, 0, 0);
    chk("t4_pv_after", pop_valid, 1);
    chk("t4_head", pop_data, 8'h7E);
    // count==1 push and pop together
    step(1, 8'h7F, 1, 0, 0); exp_q.push_back(8'h7F);
    drive(0, 8'h00, 0, 0, 0);
    chk("t4_count1", count, 1);
    chk("t4_head2", pop_data, 8'h7F);
    step(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t4_empty", count, 0);

    // Clear with a same-cycle push; entries are discarded
    step(1, 8'hC1, 0, 0, 0);
    step(1, 8'hC2, 0, 0, 0);
    step(1, 8'hC3, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t5_count3", count, 3);
    chk("t5_ovf_set", overflow, 1);
    step(1, 8'h99, 0, 1, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t5_clr_count", count, 0);
    chk("t5_clr_ovf", overflow, 0);
    chk("t5_clr_sampled", sampled, 8'h99);
    chk("t5_clr_pv", pop_valid, 0);

    // Reset mid-stream with entries stored and a push pending
    step(1, 8'hD1, 0, 0, 0);
    step(1, 8'hD2, 0, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    chk("t6_count2", count, 2);
    step(1, 8'hD3, 0, 1, 1);
    drive(0, 8'h00, 0, 0, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_pv", pop_valid, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_sampled", sampled, 0);

    // First edge after reset accepts a push
    step(1, 8'hE5, 0, 0, 0); exp_q.push_back(8'hE5);
    drive(0, 8'h00, 0, 0, 0);
    chk("t7_count", count, 1);
    chk("t7_head", pop_data, 8'hE5);
    chk("t7_sampled", sampled, 8'hE5);
    step(0, 8'h00, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 0);
    tick();
    chk("sb_leftover", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
